// File: rtl/tick_timer_pkg.sv
// Shared state type, mode encoding and channel-count limits for the tick timer bank.
package tick_timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam int CH_MIN = 1;
   localparam int CH_MAX = 8;

   function automatic bit ch_in_range(input int ch);
      return (ch >= CH_MIN) && (ch <= CH_MAX);
   endfunction

endpackage

// File: rtl/tick_timer_bank_if.sv
// Control/status bundle of the tick timer bank; the pause lane exists only
// when TICK_TIMER_PAUSE_EN is defined.
interface tick_timer_bank_if #(
   parameter int CH = 2,
   parameter int W  = 8
);
   logic            tick_in;
   logic [CH-1:0]   start;
   logic [CH-1:0]   stop;
   logic [CH-1:0]   mode;
   logic [CH*W-1:0] period;
`ifdef TICK_TIMER_PAUSE_EN
   logic [CH-1:0]   pause;
`endif
   logic [CH-1:0]   timeout;
   logic [CH-1:0]   busy;
   logic [CH*W-1:0] elapsed;

`ifdef TICK_TIMER_PAUSE_EN
   modport master (
      output tick_in, start, stop, mode, period, pause,
      input  timeout, busy, elapsed
   );
   modport slave (
      input  tick_in, start, stop, mode, period, pause,
      output timeout, busy, elapsed
   );
`else
   modport master (
      output tick_in, start, stop, mode, period,
      input  timeout, busy, elapsed
   );
   modport slave (
      input  tick_in, start, stop, mode, period,
      output timeout, busy, elapsed
   );
`endif

endinterface

// File: rtl/tick_timer_chan.sv
// One timer channel: counts base ticks up to a latched period, pulses timeout,
// one-shot or periodic. Optional pause input under TICK_TIMER_PAUSE_EN.
module tick_timer_chan
   import tick_timer_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_in,
   input  logic         start,
   input  logic         stop,
   input  logic         mode,
   input  logic [W-1:0] period,
`ifdef TICK_TIMER_PAUSE_EN
   input  logic         pause,
`endif
   output logic         timeout,
   output logic         busy,
   output logic [W-1:0] elapsed
);

   state_t       state_reg, state_next;
   logic [W-1:0] period_reg, period_next;
   logic [W-1:0] elapsed_reg, elapsed_next;
   logic         mode_reg, mode_next;
   logic         timeout_reg, timeout_next;
   logic         start_ok;
   logic         count_tick;
   logic         terminal;

   // A zero period would never complete, so such a start is simply ignored.
   assign start_ok = start && (period != '0);

`ifdef TICK_TIMER_PAUSE_EN
   assign count_tick = tick_in && !pause && (state_reg == RUN);
`else
   assign count_tick = tick_in && (state_reg == RUN);
`endif

   assign terminal = (elapsed_reg == (period_reg - W'(1)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         period_reg  <= '0;
         elapsed_reg <= '0;
         mode_reg    <= MODE_ONESHOT;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         period_reg  <= period_next;
         elapsed_reg <= elapsed_next;
         mode_reg    <= mode_next;
         timeout_reg <= timeout_next;
      end
   end

   // Priority: stop, then (re)start, then tick counting.
   always_comb begin
      state_next = state_reg;
      if (stop) begin
         state_next = IDLE;
      end else if (start_ok) begin
         state_next = RUN;
      end else if (count_tick && terminal && (mode_reg == MODE_ONESHOT)) begin
         state_next = IDLE;
      end
   end

   always_comb begin
      period_next  = period_reg;
      mode_next    = mode_reg;
      elapsed_next = elapsed_reg;
      timeout_next = 1'b0;
      if (stop) begin
         elapsed_next = '0;
      end else if (start_ok) begin
         period_next  = period;
         mode_next    = mode;
         elapsed_next = '0;
      end else if (count_tick) begin
         if (terminal) begin
            elapsed_next = '0;
            timeout_next = 1'b1;
         end else begin
            elapsed_next = elapsed_reg + W'(1);
         end
      end
   end

   assign timeout = timeout_reg;
   assign busy    = (state_reg == RUN);
   assign elapsed = elapsed_reg;

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of CH independent tick timer channels sharing one base tick.
// Build option: TICK_TIMER_PAUSE_EN adds a per-channel pause lane.
module tick_timer_bank
   import tick_timer_pkg::*;
#(
   parameter int CH = 2,
   parameter int W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   tick_timer_bank_if.slave bus
);

   if (!ch_in_range(CH)) begin : g_bad_ch
      $error("tick_timer_bank: CH out of range");
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      tick_timer_chan #(
         .W(W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .tick_in (bus.tick_in),
         .start   (bus.start[gi]),
         .stop    (bus.stop[gi]),
         .mode    (bus.mode[gi]),
         .period  (bus.period[gi*W +: W]),
`ifdef TICK_TIMER_PAUSE_EN
         .pause   (bus.pause[gi]),
`endif
         .timeout (bus.timeout[gi]),
         .busy    (bus.busy[gi]),
         .elapsed (bus.elapsed[gi*W +: W])
      );
   end

endmodule

// File: doc/tick_timer_bank.md
# tick_timer_bank

Multi-channel programmable tick timer for the trainer's timing layer. Each channel counts strobes on a shared base tick (typically the 100 ms strobe) up to a per-channel programmable period, then emits a one-cycle timeout pulse. Each channel runs in one-shot or periodic mode. The block replaces fixed-ratio dividers: 1 s, dot-display hold, and answer-window timers come from one instance.

## Interface
- `CH`, default 2: number of independent channels (1..8).
- `W`, default 8: period/elapsed counter width in bits.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `tick_in` in 1: base tick strobe, one `clk` cycle wide, shared by all channels.
- `start` in CH: per-channel start/restart request, sampled each cycle.
- `stop` in CH: per-channel abort request.
- `mode` in CH: 0 = one-shot, 1 = periodic; sampled at start.
- `period` in CH*W: channel c uses bits [c*W +: W]; terminal tick count, sampled at start.
- `pause` in CH: present only with `TICK_TIMER_PAUSE_EN`; ticks ignored while high.
- `timeout` out CH: one-cycle registered pulse per completed period.
- `busy` out CH: channel in RUN.
- `elapsed` out CH*W: ticks counted in the current period.

## Operation
- Per-channel FSM with two states, IDLE and RUN. The period and mode are latched at start. Later changes on `period`/`mode` have no effect until the next start.
- IDLE: `start`=1 with `period`≠0 → RUN, `elapsed`←0. `start` with `period`=0 is ignored and the channel stays IDLE.
- RUN, tick with `elapsed` < P−1: `elapsed`++.
- RUN, tick with `elapsed` = P−1: the period completes.
  - `timeout` pulses.
  - One-shot: → IDLE, `elapsed`←0.
  - Periodic: stay RUN, `elapsed`←0.
- `timeout` therefore fires after exactly P ticks. With P=10 and 100 ms ticks, the period is exactly 1 s.
- RUN, `stop`=1: → IDLE, `elapsed`←0, no timeout. This holds even if a terminal tick arrives in the same cycle.
- RUN, `start`=1: restart. Re-latch period/mode, `elapsed`←0, no timeout even if coincident with a terminal tick.
- `start` and `stop` in the same cycle: stop wins in either state.
- A `tick_in` in the same cycle as an accepted start is not counted. Counting begins with the next tick.
- Channels are fully independent. Activity on one channel never affects another.
- `elapsed` never exceeds P−1. There is no wrap at 2^W because P ≤ 2^W−1.

## Timing
- Reset (`rst`=0 at a `clk` edge): all channels → IDLE; `timeout`, `busy`, `elapsed` all 0 in the following cycle. This applies mid-run too: no timeout is emitted, and latched period/mode are discarded.
- Start latency: `busy`=1 in the cycle after `start` is sampled.
- Timeout latency: `timeout` is high for exactly one cycle, the cycle after the terminal `tick_in` edge.
  - In the same cycle, `elapsed` reads 0.
  - `busy` reads 0 for one-shot and 1 for periodic.
- Back-to-back periodic timeouts are separated by exactly P ticks. No tick is lost at the period boundary.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `TICK_TIMER_PAUSE_EN` defined: the `pause` port exists.
  - A RUN channel with `pause`=1 ignores `tick_in`. `elapsed` and `busy` hold.
  - `stop` and `start` still act normally while paused.
  - `pause` in IDLE has no effect.
- `TICK_TIMER_PAUSE_EN` undefined: no `pause` port; every tick in RUN counts.

## Structure
- Package `tick_timer_pkg`:
  - State typedef (IDLE, RUN).
  - Mode constants `MODE_ONESHOT`=0, `MODE_PERIODIC`=1.
  - Width-check constant for `CH` range.
- Sub-module `tick_timer_chan`: one channel (FSM, latched period/mode, counter, timeout register), parameter `W`.
- `tick_timer_bank` generates `CH` instances and slices the packed `period`/`elapsed` buses.

## Test plan
- Reset: hold `rst`=0 with `start`=1 and ticks active → all outputs 0. Release, then start ch0 with P=10, one-shot, ticks every 5 cycles → single `timeout[0]` pulse one cycle after the 10th tick; `busy[0]` falls in that same cycle.
- Periodic: ch1 with P=3 → `timeout[1]` after ticks 3, 6, 9; `elapsed` sequence 0,1,2,0,1,2; `busy[1]` stays 1.
- Coincidence: `stop` on the terminal tick → no timeout, IDLE. Restart on the terminal tick → no timeout, `elapsed`=0, new P latched. `start`+`stop` together → IDLE.
- Edge values: P=0 start → ignored. P=1 → timeout on every tick. P=2^W−1 → counts to 2^W−2, then times out with no wrap. Tick coincident with start → not counted.
- Reset mid-run: at `elapsed`=7 of P=10, assert `rst` → outputs 0 next cycle; no timeout ever fires for that run.
- `TICK_TIMER_PAUSE_EN`: P=4, pause for 3 ticks after tick 2 → timeout after tick 7 overall; `elapsed` holds at 2 during pause.
